hazard_scoreboard: RTL

Parametrised hazard and forwarding unit for the pipelined MIPS core. It replaces per-opcode forwarding decode with a Tuse/Tnew scoreboard. Each in-flight instruction's destination register and remaining result latency shift through a register-per-stage pipeline. From that pipeline the block generates forwarding selects for every consumer stage, a decode stall, and HI/LO multiply/divide busy interlocking. It sits beside the decoder. The decoder supplies per-instruction register use, Tuse and Tnew, and the datapath muxes consume the selects.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decoder/datapath and the hazard scoreboard.
// The decoder drives the D-stage fields; the scoreboard returns stall, busy and forward selects.
interface hazard_scoreboard_if #(
    parameter int REG_W  = 5,
    parameter int NSTAGE = 3,
    parameter int TNEW_W = 2,
    parameter int SELW   = $clog2(NSTAGE + 1)
);
    logic                   d_valid;
    logic [REG_W-1:0]       d_rs;
    logic [REG_W-1:0]       d_rt;
    logic                   d_rs_use;
    logic                   d_rt_use;
    logic [TNEW_W-1:0]      d_rs_tuse;
    logic [TNEW_W-1:0]      d_rt_tuse;
    logic [REG_W-1:0]       d_dst;
    logic [TNEW_W-1:0]      d_tnew;
    logic                   d_md;
    logic                   d_md_start;
    logic                   d_md_div;
    logic                   stall;
    logic                   md_busy;
    logic [NSTAGE*SELW-1:0] fwd_rs;
    logic [NSTAGE*SELW-1:0] fwd_rt;

    modport master (
        output d_valid, d_rs, d_rt, d_rs_use, d_rt_use, d_rs_tuse, d_rt_tuse,
               d_dst, d_tnew, d_md, d_md_start, d_md_div,
        input  stall, md_busy, fwd_rs, fwd_rt
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_rs_use, d_rt_use, d_rs_tuse, d_rt_tuse,
               d_dst, d_tnew, d_md, d_md_start, d_md_div,
        output stall, md_busy, fwd_rs, fwd_rt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard: shifts per-stage {dst, tnew, sources} and derives
// forward selects for every consumer stage, the D stall and HI/LO busy interlock.
module hazard_scoreboard #(
    parameter int REG_W    = 5,
    parameter int NSTAGE   = 3,
    parameter int TNEW_W   = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SELW     = $clog2(NSTAGE + 1)
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);
    localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNT_W  = $clog2(MD_MAX + 1);

    logic [REG_W-1:0]  e_dst    [1:NSTAGE];
    logic [TNEW_W-1:0] e_tnew   [1:NSTAGE];
    logic [REG_W-1:0]  e_rs     [1:NSTAGE];
    logic [REG_W-1:0]  e_rt     [1:NSTAGE];
    logic              e_rs_use [1:NSTAGE];
    logic              e_rt_use [1:NSTAGE];

    // consumer view: index 0 is D, index j>=1 is the entry sitting in stage j
    logic [REG_W-1:0]  c_rs     [0:NSTAGE-1];
    logic [REG_W-1:0]  c_rt     [0:NSTAGE-1];
    logic              c_rs_use [0:NSTAGE-1];
    logic              c_rt_use [0:NSTAGE-1];

    logic [CNT_W-1:0]       md_cnt;
    logic                   issue;
    logic                   rs_stall;
    logic                   rt_stall;
    logic                   md_stall;
    logic                   stall_w;
    logic                   rs_hit;
    logic                   rt_hit;
    logic [SELW-1:0]        rs_k;
    logic [SELW-1:0]        rt_k;
    logic [TNEW_W-1:0]      rs_t;
    logic [TNEW_W-1:0]      rt_t;
    logic [NSTAGE*SELW-1:0] fwd_rs_w;
    logic [NSTAGE*SELW-1:0] fwd_rt_w;

    always_comb begin
        c_rs[0]     = hz.d_rs;
        c_rt[0]     = hz.d_rt;
        c_rs_use[0] = hz.d_rs_use;
        c_rt_use[0] = hz.d_rt_use;
        for (int unsigned j = 1; j < NSTAGE; j++) begin
            c_rs[j]     = e_rs[j];
            c_rt[j]     = e_rt[j];
            c_rs_use[j] = e_rs_use[j];
            c_rt_use[j] = e_rt_use[j];
        end
    end

    always_comb begin
        rs_stall = 1'b0;
        rt_stall = 1'b0;
        fwd_rs_w = '0;
        fwd_rt_w = '0;
        rs_hit   = 1'b0;
        rt_hit   = 1'b0;
        rs_k     = '0;
        rt_k     = '0;
        rs_t     = '0;
        rt_t     = '0;
        for (int unsigned j = 0; j < NSTAGE; j++) begin
            rs_hit = 1'b0;
            rt_hit = 1'b0;
            rs_k   = '0;
            rt_k   = '0;
            rs_t   = '0;
            rt_t   = '0;
            // scan oldest-first so the nearest (youngest) writer overrides older ones
            for (int unsigned k = NSTAGE; k > j; k--) begin
                if (c_rs_use[j] && (c_rs[j] != '0) && (c_rs[j] == e_dst[k])) begin
                    rs_hit = 1'b1;
                    rs_k   = SELW'(k);
                    rs_t   = e_tnew[k];
                end
                if (c_rt_use[j] && (c_rt[j] != '0) && (c_rt[j] == e_dst[k])) begin
                    rt_hit = 1'b1;
                    rt_k   = SELW'(k);
                    rt_t   = e_tnew[k];
                end
            end
            if (rs_hit && (rs_t == '0)) fwd_rs_w[j*SELW +: SELW] = rs_k;
            if (rt_hit && (rt_t == '0)) fwd_rt_w[j*SELW +: SELW] = rt_k;
            if (j == 0) begin
                rs_stall = rs_hit && (rs_t > hz.d_rs_tuse);
                rt_stall = rt_hit && (rt_t > hz.d_rt_tuse);
            end
        end
    end

    assign md_stall   = hz.d_valid && hz.d_md && (md_cnt != '0);
    assign stall_w    = rs_stall || rt_stall || md_stall;
    assign issue      = hz.d_valid && !stall_w;
    assign hz.stall   = stall_w;
    assign hz.md_busy = (md_cnt != '0);
    assign hz.fwd_rs  = fwd_rs_w;
    assign hz.fwd_rt  = fwd_rt_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 1; k <= NSTAGE; k++) begin
                e_dst[k]    <= '0;
                e_tnew[k]   <= '0;
                e_rs[k]     <= '0;
                e_rt[k]     <= '0;
                e_rs_use[k] <= 1'b0;
                e_rt_use[k] <= 1'b0;
            end
        end else begin
            e_dst[1]    <= issue ? hz.d_dst : '0;
            e_tnew[1]   <= issue ? hz.d_tnew : '0;
            e_rs[1]     <= hz.d_rs;
            e_rt[1]     <= hz.d_rt;
            e_rs_use[1] <= issue && hz.d_rs_use;
            e_rt_use[1] <= issue && hz.d_rt_use;
            for (int unsigned k = 2; k <= NSTAGE; k++) begin
                e_dst[k]    <= e_dst[k-1];
                e_tnew[k]   <= (e_tnew[k-1] == '0) ? '0 : e_tnew[k-1] - 1'b1;
                e_rs[k]     <= e_rs[k-1];
                e_rt[k]     <= e_rt[k-1];
                e_rs_use[k] <= e_rs_use[k-1];
                e_rt_use[k] <= e_rt_use[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (issue && hz.d_md_start) begin
            md_cnt <= hz.d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end
endmodule
